seg_display_arbiter: RTL and testbench

- Shares one multiplexed NUMCELLS-digit seven-segment display between NUMREQ requesters.
- Round-robin arbitration with a guaranteed minimum dwell time per owner.
- Converts the owner's hex nibbles plus decimal-point bits into segment bytes.
- Drives the scanner's cellvalin bus directly.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_rr_pick.sv | 32 +++
 rtl/seg_display_arbiter.sv | 83 ++++++++
 tb/tb_seg_display_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, FSM states and hex-to-segment encoding for the display arbiter
package seg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;
  // Segment byte: bit0 = A ... bit6 = G, bit7 = decimal point, active-high.
  function automatic logic [7:0] seg_encode(input logic [3:0] n, input logic d);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return {d, s};
  endfunction
endpackage

// File: rtl/seg_rr_pick.sv
// seg_rr_pick: combinational round-robin picker searching upward (with wrap) from ptr+1
//   req  : request vector
//   ptr  : last winner; the search starts just above it
//   excl : when set, the requester at ptr is not eligible
//   win  : one-hot winner, idx : winner index (ptr when none), any : a winner exists
module seg_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          excl,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] m;
  assign m = req & ~({{(N-1){1'b0}}, excl} << ptr);
  // ptr itself is visited last (i == N), so it only wins when nobody else asks.
  always_comb begin
    win = '0;
    idx = ptr;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && m[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        win[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of a multiplexed seven-segment display with minimum dwell
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   req            : level request per requester
//   nib, dp        : per-requester hex digits and decimal points, top of each slice is leftmost cell
//   grant          : one-hot owner or zero; owner_idx : owner index, held while idle
//   cellvalin      : registered segment bytes for the scanner, top byte is leftmost cell
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int NUMCELLS = 4,
  parameter int NUMREQ   = 3,
  parameter int DWELL    = 50000,
  parameter int DWELL_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUMREQ-1:0]            req,
  input  logic [NUMREQ*4*NUMCELLS-1:0] nib,
  input  logic [NUMREQ*NUMCELLS-1:0]   dp,
  output logic [NUMREQ-1:0]            grant,
  output logic [$clog2(NUMREQ)-1:0]    owner_idx,
  output logic [8*NUMCELLS-1:0]        cellvalin
);
  localparam int IW = $clog2(NUMREQ);
  state_t                state;
  logic [DWELL_W-1:0]    cnt;
  logic [IW-1:0]         ptr;
  logic [NUMREQ-1:0]     win;
  logic [IW-1:0]         idx;
  logic                  any;
  logic [4*NUMCELLS-1:0] own_nib;
  logic [NUMCELLS-1:0]   own_dp;
  logic [8*NUMCELLS-1:0] enc;
  // In OPEN the owner is excluded so any hit means someone else is waiting.
  seg_rr_pick #(.N(NUMREQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .excl (state == OPEN),
    .win  (win),
    .idx  (idx),
    .any  (any)
  );
  always_comb begin
    own_nib = '0;
    own_dp  = '0;
    for (int r = 0; r < NUMREQ; r++) begin
      if (owner_idx == IW'(r)) begin
        own_nib = nib[r*4*NUMCELLS +: 4*NUMCELLS];
        own_dp  = dp[r*NUMCELLS +: NUMCELLS];
      end
    end
  end
  for (genvar c = 0; c < NUMCELLS; c++) begin : g_enc
    assign enc[8*c +: 8] = seg_encode(own_nib[4*c +: 4], own_dp[c]);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      owner_idx <= '0;
      ptr       <= IW'(NUMREQ - 1);
      cnt       <= '0;
      cellvalin <= {NUMCELLS{SEG_BLANK}};
    end else begin
      // Live data follows the owner only while it keeps requesting; otherwise it freezes.
      if (state != IDLE && req[owner_idx]) cellvalin <= enc;
      if ((state == IDLE || state == OPEN) && any) begin
        grant     <= win;
        owner_idx <= idx;
        ptr       <= idx;
        cnt       <= DWELL_W'(DWELL - 1);
        state     <= HOLD;
      end else if (state == HOLD) begin
        cnt   <= cnt - 1'b1;
        state <= cnt == DWELL_W'(1) ? OPEN : HOLD;
      end else if (state == OPEN && !req[owner_idx]) begin
        grant     <= '0;
        cellvalin <= {NUMCELLS{SEG_BLANK}};
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: randomized scoreboard bench against an ownership-counting reference model
module tb_seg_display_arbiter;
  localparam int NC = 4;
  localparam int NR = 3;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*4*NC-1:0] nib = '0;
  logic [NR*NC-1:0]   dp = '0;
  logic [NR-1:0]   grant;
  logic [1:0]      owner_idx;
  logic [8*NC-1:0] cellvalin;

  seg_display_arbiter #(.NUMCELLS(NC), .NUMREQ(NR), .DWELL(DW), .DWELL_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .nib       (nib),
    .dp        (dp),
    .grant     (grant),
    .owner_idx (owner_idx),
    .cellvalin (cellvalin)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NR-1:0]   g;
    logic [1:0]      i;
    logic [8*NC-1:0] c;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  byte unsigned tbl[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [8*NC-1:0] show(input int r);
    logic [8*NC-1:0] v;
    for (int c = 0; c < NC; c++)
      v[8*c +: 8] = tbl[nib[r*4*NC + 4*c +: 4]] | (dp[r*NC + c] ? 8'h80 : 8'h00);
    return v;
  endfunction

  // First requester strictly after 'from' in circular order, never 'skip'.
  function automatic int next_req(input int from, input int skip);
    for (int k = 1; k <= NR; k++)
      if (req[(from + k) % NR] && (from + k) % NR != skip) return (from + k) % NR;
    return -1;
  endfunction

  int own, last, idx, held, w;
  logic [8*NC-1:0] disp;

  // Model: an owner keeps the display for 'held' = 1..DW cycles, then yields to anyone else.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      own = -1; last = NR - 1; idx = 0; held = 0; disp = '0;
      q.delete();
    end else begin
      if (own >= 0 && req[own]) disp = show(own);
      if (own < 0) begin
        w = next_req(last, -1);
        if (w >= 0) begin own = w; last = w; idx = w; held = 1; end
      end else if (held < DW) held++;
      else begin
        w = next_req(own, own);
        if (w >= 0) begin own = w; last = w; idx = w; held = 1; end
        else if (!req[own]) begin own = -1; disp = '0; end
      end
      q.push_back('{own < 0 ? NR'(0) : NR'(1) << own, 2'(idx), disp});
    end
  end

  exp_t e;
  always @(posedge clock) begin
    #2;
    if (reset_n && q.size() > 0) begin
      e = q.pop_front();
      check("grant", 32'(grant), 32'(e.g));
      check("owner_idx", 32'(owner_idx), 32'(e.i));
      check("cellvalin", cellvalin, e.c);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  int zeros;

  initial begin
    #1;
    check("reset grant", 32'(grant), 0);
    check("reset owner_idx", 32'(owner_idx), 0);
    check("reset cellvalin", cellvalin, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    nib[15:0] = 16'h12AF;
    dp[3:0] = 4'b0100;
    req = 3'b001;
    @(posedge clock); #2;
    check("latency grant", 32'(grant), 1);
    @(posedge clock); #2;
    check("latency cellvalin", cellvalin, 32'h06DB7771);
    @(negedge clock) nib[3:0] = 4'h0;
    @(posedge clock); #2;
    check("live digit 0", 32'(cellvalin[7:0]), 32'h3F);
    @(negedge clock) nib[3:0] = 4'hF;
    @(posedge clock); #2;
    check("live digit F", 32'(cellvalin[7:0]), 32'h71);
    @(negedge clock) req = 3'b011;
    zeros = 0;
    repeat (48) begin
      @(posedge clock); #2;
      if (grant == 0) zeros++;
    end
    check("no idle gaps", 32'(zeros), 0);
    @(negedge clock) req = 3'b000;
    cyc(12);
    check("idle grant", 32'(grant), 0);
    req = 3'b100;
    cyc(3);
    req = 3'b101;
    cyc(3);
    req = 3'b100;
    cyc(1);
    check("pulse ignored", 32'(grant), 32'b100);
    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        nib = {$urandom, $urandom};
        dp = NR*NC'($urandom);
      end
    end
    req = 3'b010;
    cyc(4);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("async reset grant", 32'(grant), 0);
    check("async reset cellvalin", cellvalin, 0);
    check("async reset owner_idx", 32'(owner_idx), 0);
    @(negedge clock);
    reset_n = 1'b1;
    req = 3'b111;
    @(posedge clock); #2;
    check("post-reset first winner", 32'(grant), 1);
    cyc(30);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
